// File: rtl/nibble_alu.sv
// nibble_alu: 16-bit ALU for the QUAD.nibble datapath with a one-cycle registered result.
module nibble_alu (
   input  logic        clk,
   input  logic        resetn,
   input  logic [3:0]  ctrl_i,
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [15:0] y_o
);
   localparam logic [3:0] ALU_OP_ADD = 4'h0;
   localparam logic [3:0] ALU_OP_SUB = 4'h1;
   localparam logic [3:0] ALU_OP_MUL = 4'h2;
   localparam logic [3:0] ALU_OP_AND = 4'h3;
   localparam logic [3:0] ALU_OP_OR  = 4'h4;
   localparam logic [3:0] ALU_OP_XOR = 4'h5;
   localparam logic [3:0] ALU_OP_NOR = 4'h6;
   localparam logic [3:0] ALU_OP_SLL = 4'h7;
   localparam logic [3:0] ALU_OP_SRL = 4'h8;
   localparam logic [3:0] ALU_OP_ROL = 4'h9;
   localparam logic [3:0] ALU_OP_SWP = 4'hA;

   logic signed [31:0] prod;
   logic        [31:0] rot;
   logic               big_shift;
   logic        [15:0] y_d, y_q;

   assign prod      = $signed(a_i) * $signed(b_i);
   assign rot       = {a_i, a_i} << b_i[3:0];
   // shift amounts are unsigned; anything 16 or above empties the word
   assign big_shift = |b_i[15:4];

   always_comb begin
      y_d = 16'h0000;
      case (ctrl_i)
         ALU_OP_ADD: y_d = a_i + b_i;
         ALU_OP_SUB: y_d = a_i - b_i;
         ALU_OP_MUL: y_d = prod[15:0];
         ALU_OP_AND: y_d = a_i & b_i;
         ALU_OP_OR:  y_d = a_i | b_i;
         ALU_OP_XOR: y_d = a_i ^ b_i;
         ALU_OP_NOR: y_d = ~(a_i | b_i);
         ALU_OP_SLL: y_d = big_shift ? 16'h0000 : a_i << b_i[3:0];
         ALU_OP_SRL: y_d = big_shift ? 16'h0000 : a_i >> b_i[3:0];
         ALU_OP_ROL: y_d = rot[31:16];
         ALU_OP_SWP: y_d = {a_i[11:8], a_i[15:12], a_i[3:0], a_i[7:4]};
         default:    y_d = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or posedge resetn)
      if (resetn) y_q <= 16'h0000;
      else        y_q <= y_d;

   assign y_o = y_q;
endmodule

// File: tb/tb_nibble_alu.sv
// tb_nibble_alu: table-driven scoreboard bench for nibble_alu.
module tb_nibble_alu;
   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic [3:0]  ctrl = 4'h0;
   logic [15:0] a = 16'h0003, b = 16'h0004;
   logic [15:0] y;
   int          total = 0, bad = 0;
   logic [15:0] sb[$];

   typedef struct {
      logic [3:0]  c;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] e;
   } vec_t;
   vec_t tv[$];

   nibble_alu dut (.clk(clk), .resetn(resetn), .ctrl_i(ctrl), .a_i(a), .b_i(b), .y_o(y));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [15:0] exp);
      total++;
      if (y !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, y, exp);
      end
   endtask

   task automatic run(input string nm, input logic [3:0] c, input logic [15:0] av, bv, ev);
      ctrl = c; a = av; b = bv;
      sb.push_back(ev);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         total++; bad++;
         $display("FAIL %s: scoreboard empty", nm);
      end else check(nm, sb.pop_front());
   endtask

   initial begin
      tv.push_back('{4'h0, 16'h0003, 16'h0004, 16'h0007});
      tv.push_back('{4'h0, 16'h7FFF, 16'h0001, 16'h8000});
      tv.push_back('{4'h0, 16'hA000, 16'hA000, 16'h4000});
      tv.push_back('{4'h1, 16'h0003, 16'h0004, 16'hFFFF});
      tv.push_back('{4'h1, 16'h8000, 16'h0001, 16'h7FFF});
      tv.push_back('{4'h2, 16'h0003, 16'h0004, 16'h000C});
      tv.push_back('{4'h2, 16'h4000, 16'h4000, 16'h0000});
      tv.push_back('{4'h2, 16'hFFFF, 16'h8000, 16'h8000});
      tv.push_back('{4'h2, 16'hFFFD, 16'h0005, 16'hFFF1});
      tv.push_back('{4'h3, 16'h5A5A, 16'hA5A5, 16'h0000});
      tv.push_back('{4'h4, 16'h5A5A, 16'hA5A5, 16'hFFFF});
      tv.push_back('{4'h5, 16'h5A5A, 16'hA5A5, 16'hFFFF});
      tv.push_back('{4'h6, 16'h5A5A, 16'hA5A5, 16'h0000});
      tv.push_back('{4'h3, 16'hF00F, 16'hF0F0, 16'hF000});
      tv.push_back('{4'h4, 16'hF00F, 16'h0F00, 16'hFF0F});
      tv.push_back('{4'h5, 16'hF00F, 16'hFF00, 16'h0F0F});
      tv.push_back('{4'h6, 16'hF00F, 16'h0F00, 16'h00F0});
      tv.push_back('{4'h7, 16'hF0F0, 16'h0008, 16'hF000});
      tv.push_back('{4'h8, 16'hF0F0, 16'h0008, 16'h00F0});
      tv.push_back('{4'h9, 16'hF0F0, 16'h0008, 16'hF0F0});
      tv.push_back('{4'h7, 16'hFFFF, 16'h0010, 16'h0000});
      tv.push_back('{4'h8, 16'hFFFF, 16'h0010, 16'h0000});
      tv.push_back('{4'h7, 16'hFFFF, 16'h0020, 16'h0000});
      tv.push_back('{4'h8, 16'hFFFF, 16'h0020, 16'h0000});
      tv.push_back('{4'h7, 16'hFFFF, 16'h8000, 16'h0000});
      tv.push_back('{4'h8, 16'hFFFF, 16'h8000, 16'h0000});
      tv.push_back('{4'h9, 16'hFFFF, 16'h0010, 16'hFFFF});
      tv.push_back('{4'h7, 16'h0001, 16'h000F, 16'h8000});
      tv.push_back('{4'h8, 16'h8000, 16'h000F, 16'h0001});
      tv.push_back('{4'h8, 16'h8421, 16'h0001, 16'h4210});
      tv.push_back('{4'h9, 16'h1234, 16'h0004, 16'h2341});
      tv.push_back('{4'h9, 16'h8001, 16'h0001, 16'h0003});
      tv.push_back('{4'h9, 16'h1234, 16'h0014, 16'h2341});
      tv.push_back('{4'h9, 16'h1234, 16'h0020, 16'h1234});
      tv.push_back('{4'hA, 16'h0F0F, 16'h0000, 16'hF0F0});
      tv.push_back('{4'hA, 16'h1234, 16'h0000, 16'h2143});
      tv.push_back('{4'hA, 16'h8080, 16'h0000, 16'h0808});
      tv.push_back('{4'hA, 16'h00FF, 16'h0005, 16'h00FF});
      tv.push_back('{4'hB, 16'hFFFF, 16'hFFFF, 16'h0000});
      tv.push_back('{4'h0, 16'h0001, 16'h0001, 16'h0002});
      tv.push_back('{4'hC, 16'hFFFF, 16'hFFFF, 16'h0000});
      tv.push_back('{4'h4, 16'h1234, 16'h0000, 16'h1234});
      tv.push_back('{4'hD, 16'h1234, 16'h0001, 16'h0000});
      tv.push_back('{4'h4, 16'h1234, 16'h0000, 16'h1234});
      tv.push_back('{4'hE, 16'h1234, 16'h0001, 16'h0000});
      tv.push_back('{4'h4, 16'h1234, 16'h0000, 16'h1234});
      tv.push_back('{4'hF, 16'h1234, 16'h0001, 16'h0000});

      #12;
      check("reset_hold", 16'h0000);
      resetn = 1'b0;
      foreach (tv[i])
         run($sformatf("vec%0d_op%h", i, tv[i].c), tv[i].c, tv[i].a, tv[i].b, tv[i].e);

      run("pre_reset", 4'h0, 16'h1111, 16'h2222, 16'h3333);
      #2 resetn = 1'b1;
      #1 check("async_reset", 16'h0000);
      ctrl = 4'h0; a = 16'h0005; b = 16'h0005;
      @(posedge clk);
      #1 check("reset_held_edge", 16'h0000);
      #2 resetn = 1'b0;
      run("post_reset_add", 4'h0, 16'h0001, 16'h0001, 16'h0002);
      run("reserved_f", 4'hF, 16'hFFFF, 16'h0001, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
